// File: rtl/cdb_rs_if.sv
// cdb_rs_if: issue, CDB snoop and dispatch signals of one reservation station.
// master drives issue/CDB/accept; slave is the station itself.
interface cdb_rs_if #(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              in_issue_valid;
   logic              out_issue_ready;
   logic [OP_W-1:0]   in_issue_op;
   logic [TAG_W-1:0]  in_issue_qj;
   logic [TAG_W-1:0]  in_issue_qk;
   logic [DATA_W-1:0] in_issue_vj;
   logic [DATA_W-1:0] in_issue_vk;
   logic [TAG_W-1:0]  out_issue_tag;
   logic              in_broadcast;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] in_val;
   logic              out_dispatch_valid;
   logic              in_dispatch_ready;
   logic [OP_W-1:0]   out_dispatch_op;
   logic [DATA_W-1:0] out_dispatch_vj;
   logic [DATA_W-1:0] out_dispatch_vk;
   logic [TAG_W-1:0]  out_dispatch_tag;

   modport master (
      output in_issue_valid, in_issue_op, in_issue_qj, in_issue_qk,
      output in_issue_vj, in_issue_vk,
      output in_broadcast, in_tag, in_val, in_dispatch_ready,
      input  out_issue_ready, out_issue_tag,
      input  out_dispatch_valid, out_dispatch_op,
      input  out_dispatch_vj, out_dispatch_vk, out_dispatch_tag
   );

   modport slave (
      input  in_issue_valid, in_issue_op, in_issue_qj, in_issue_qk,
      input  in_issue_vj, in_issue_vk,
      input  in_broadcast, in_tag, in_val, in_dispatch_ready,
      output out_issue_ready, out_issue_tag,
      output out_dispatch_valid, out_dispatch_op,
      output out_dispatch_vj, out_dispatch_vk, out_dispatch_tag
   );
endinterface

// File: rtl/cdb_rs.sv
// cdb_rs: reservation station that snoops the CDB and feeds one functional unit.
// Option CDB_RS_BYPASS_EN: capture a same-cycle broadcast into the issuing entry.
module cdb_rs #(
   parameter int ENTRIES  = 4,
   parameter int TAG_W    = 5,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 4,
   parameter int BASE_TAG = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   cdb_rs_if.slave  bus
);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] r_busy;
   logic [ENTRIES-1:0] r_disp;
   logic [OP_W-1:0]    r_op [ENTRIES];
   logic [TAG_W-1:0]   r_qj [ENTRIES];
   logic [TAG_W-1:0]   r_qk [ENTRIES];
   logic [DATA_W-1:0]  r_vj [ENTRIES];
   logic [DATA_W-1:0]  r_vk [ENTRIES];

   logic [ENTRIES-1:0] w_ready;
   logic               w_free_any;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_rdy_any;
   logic [IDX_W-1:0]   w_rdy_idx;
   logic               w_snoop;
   logic               w_hit_j;
   logic               w_hit_k;
   logic               w_hazard;
   logic               w_issue_ready;
   logic               w_issue_fire;
   logic               w_disp_fire;
   logic [TAG_W-1:0]   w_new_qj;
   logic [TAG_W-1:0]   w_new_qk;
   logic [DATA_W-1:0]  w_new_vj;
   logic [DATA_W-1:0]  w_new_vk;

   // lowest free entry and lowest ready entry (descending scan keeps lowest)
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_rdy_any  = 1'b0;
      w_rdy_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         w_ready[i] = r_busy[i] && !r_disp[i]
                      && (r_qj[i] == '0) && (r_qk[i] == '0);
         if (!r_busy[i]) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (w_ready[i]) begin
            w_rdy_any = 1'b1;
            w_rdy_idx = IDX_W'(i);
         end
      end
   end

   // same-cycle CDB match against the incoming issue operands
   always_comb begin
      w_snoop = bus.in_broadcast && (bus.in_tag != '0);
      w_hit_j = w_snoop && (bus.in_issue_qj != '0)
                && (bus.in_issue_qj == bus.in_tag);
      w_hit_k = w_snoop && (bus.in_issue_qk != '0)
                && (bus.in_issue_qk == bus.in_tag);
`ifdef CDB_RS_BYPASS_EN
      w_hazard = 1'b0;
      w_new_qj = w_hit_j ? '0 : bus.in_issue_qj;
      w_new_vj = w_hit_j ? bus.in_val : bus.in_issue_vj;
      w_new_qk = w_hit_k ? '0 : bus.in_issue_qk;
      w_new_vk = w_hit_k ? bus.in_val : bus.in_issue_vk;
`else
      // without bypass the issue stalls so the broadcast is not lost
      w_hazard = w_hit_j || w_hit_k;
      w_new_qj = bus.in_issue_qj;
      w_new_vj = bus.in_issue_vj;
      w_new_qk = bus.in_issue_qk;
      w_new_vk = bus.in_issue_vk;
`endif
   end

   // issue and dispatch handshakes, outputs zeroed when idle
   always_comb begin
      w_issue_ready = rst_n && w_free_any && !w_hazard;
      w_issue_fire  = w_issue_ready && bus.in_issue_valid;
      w_disp_fire   = w_rdy_any && bus.in_dispatch_ready;
      bus.out_issue_ready    = w_issue_ready;
      bus.out_issue_tag      = w_issue_ready
                               ? TAG_W'(BASE_TAG) + TAG_W'(w_free_idx) : '0;
      bus.out_dispatch_valid = w_rdy_any;
      bus.out_dispatch_op    = w_rdy_any ? r_op[w_rdy_idx] : '0;
      bus.out_dispatch_vj    = w_rdy_any ? r_vj[w_rdy_idx] : '0;
      bus.out_dispatch_vk    = w_rdy_any ? r_vk[w_rdy_idx] : '0;
      bus.out_dispatch_tag   = w_rdy_any
                               ? TAG_W'(BASE_TAG) + TAG_W'(w_rdy_idx) : '0;
   end

   // per-entry state: issue write, operand capture, dispatch mark, free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_disp <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_op[i] <= '0;
            r_qj[i] <= '0;
            r_qk[i] <= '0;
            r_vj[i] <= '0;
            r_vk[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_issue_fire && (w_free_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_disp[i] <= 1'b0;
               r_op[i]   <= bus.in_issue_op;
               r_qj[i]   <= w_new_qj;
               r_vj[i]   <= w_new_vj;
               r_qk[i]   <= w_new_qk;
               r_vk[i]   <= w_new_vk;
            end else if (r_busy[i]) begin
               if (w_snoop && (r_qj[i] == bus.in_tag)) begin
                  r_qj[i] <= '0;
                  r_vj[i] <= bus.in_val;
               end
               if (w_snoop && (r_qk[i] == bus.in_tag)) begin
                  r_qk[i] <= '0;
                  r_vk[i] <= bus.in_val;
               end
               if (w_disp_fire && (w_rdy_idx == IDX_W'(i))) begin
                  r_disp[i] <= 1'b1;
               end
               // free wins over a coincident dispatch
               if (bus.in_broadcast
                   && (bus.in_tag == TAG_W'(BASE_TAG + i))) begin
                  r_busy[i] <= 1'b0;
               end
            end
         end
      end
   end
endmodule
